// File: rtl/bias_act_stream_if.sv
// Stream, bias-write and channel-clear signals between the MAC array and the bias/activation stage.
// The master drives accumulator beats and bias writes; the slave returns requantised results.
interface bias_act_stream_if #(
  parameter int N_CH  = 16,
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
);
  localparam int CH_W = $clog2(N_CH);

  logic                    bias_we;
  logic [CH_W-1:0]         bias_addr;
  logic signed [ACC_W-1:0] bias_wdata;
  logic                    ch_clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic [CH_W-1:0]         out_ch;

  modport master (
    output bias_we, bias_addr, bias_wdata, ch_clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  bias_we, bias_addr, bias_wdata, ch_clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/bias_act_stream.sv
// Per-channel bias add, arithmetic-shift requantise, saturation and optional ReLU on an
// accumulator stream; two-stage pipeline under a single global enable.
module bias_act_stream #(
  parameter int N_CH    = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 8,
  parameter int RELU_EN = 1
) (
  input logic           clk,
  input logic           rst,
  bias_act_stream_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_CH - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] bias [N_CH];
  logic [CH_W-1:0]         ch_cnt;
  logic signed [ACC_W-1:0] cur_bias;

  logic                    s1_valid;
  logic signed [ACC_W:0]   s1_sum;
  logic [CH_W-1:0]         s1_ch;

  logic                    en;
  logic                    accept;
  logic signed [ACC_W:0]   shifted;
  logic signed [OUT_W-1:0] act;

  logic                    out_valid_q;
  logic signed [OUT_W-1:0] out_data_q;
  logic [CH_W-1:0]         out_ch_q;

  // A stall (result held and not taken) freezes both stages together.
  assign en           = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && en;
  assign cur_bias     = bias[ch_cnt];
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  always_comb begin
    shifted = s1_sum >>> SHIFT;
    if (shifted > SAT_MAX)
      act = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN)
      act = SAT_MIN[OUT_W-1:0];
    else
      act = shifted[OUT_W-1:0];
    if (RELU_EN != 0 && shifted[ACC_W])
      act = '0;
  end

  // Bias writes land at the edge, so a beat accepted in the same cycle still reads the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++)
        bias[i] <= '0;
    end else if (bus.bias_we && (int'(bus.bias_addr) < N_CH)) begin
      bias[bus.bias_addr] <= bus.bias_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ch_cnt <= '0;
    else if (bus.ch_clr)
      ch_cnt <= '0;
    else if (accept)
      ch_cnt <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_sum      <= '0;
      s1_ch       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else if (en) begin
      s1_valid    <= accept;
      out_valid_q <= s1_valid;
      if (accept) begin
        s1_sum <= {bus.in_data[ACC_W-1], bus.in_data} + {cur_bias[ACC_W-1], cur_bias};
        s1_ch  <= ch_cnt;
      end
      if (s1_valid) begin
        out_data_q <= act;
        out_ch_q   <= s1_ch;
      end
    end
  end
endmodule

// File: tb/tb_bias_act_stream.sv
// Self-checking bench for bias_act_stream: randomized beats scored against a queue-based
// arithmetic model, plus fixed-value scenarios on a ReLU and a non-ReLU (12-channel) instance.
module tb_bias_act_stream;
  localparam int N_CH  = 16;
  localparam int N2    = 12;
  localparam int SHIFT = 8;

  typedef struct {
    logic signed [15:0] data;
    logic [3:0]         ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bias_act_stream_if #(.N_CH(N_CH), .ACC_W(32), .OUT_W(16)) bus ();
  bias_act_stream_if #(.N_CH(N2),   .ACC_W(32), .OUT_W(16)) bus2 ();

  bias_act_stream #(.N_CH(N_CH), .ACC_W(32), .OUT_W(16), .SHIFT(SHIFT), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  bias_act_stream #(.N_CH(N2), .ACC_W(32), .OUT_W(16), .SHIFT(SHIFT), .RELU_EN(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int errors = 0;
  int checks = 0;

  exp_t    exp_q[$];
  longint  bias_m [N_CH];
  int      ch_m;

  logic               got_hand, got_acc, exp_ok;
  logic signed [15:0] got_data, exp_data;
  logic [3:0]         got_ch, exp_ch;
  logic               snap_in_ready, snap_out_valid;
  logic signed [15:0] snap_data;
  logic [3:0]         snap_ch;

  function automatic logic signed [15:0] act_model(longint acc, longint b, bit relu);
    longint t;
    t = (acc + b) >>> SHIFT;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    if (relu && t < 0) t = 0;
    return 16'(t);
  endfunction

  task automatic drive_idle();
    bus.bias_we = 0; bus.bias_addr = '0; bus.bias_wdata = '0; bus.ch_clr = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    bus2.bias_we = 0; bus2.bias_addr = '0; bus2.bias_wdata = '0; bus2.ch_clr = 0;
    bus2.in_valid = 0; bus2.in_data = '0; bus2.out_ready = 1;
  endtask

  // Samples at the falling edge: retires a handed-off result, books accepted beats, then applies
  // clear and bias write so a same-cycle beat sees the old channel and old bias.
  task automatic clock_cycle();
    exp_t e;
    @(negedge clk);
    got_hand = 0; got_acc = 0; exp_ok = 0;
    snap_in_ready = bus.in_ready; snap_out_valid = bus.out_valid;
    snap_data = bus.out_data; snap_ch = bus.out_ch;
    if (rst) begin
      exp_q.delete();
      for (int i = 0; i < N_CH; i++) bias_m[i] = 0;
      ch_m = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        got_hand = 1; got_data = bus.out_data; got_ch = bus.out_ch;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          exp_ok = 1; exp_data = e.data; exp_ch = e.ch;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        got_acc = 1;
        e.data = act_model(longint'(bus.in_data), bias_m[ch_m], 1'b1);
        e.ch   = 4'(ch_m);
        exp_q.push_back(e);
        ch_m = (ch_m + 1) % N_CH;
      end
      if (bus.ch_clr) ch_m = 0;
      if (bus.bias_we && int'(bus.bias_addr) < N_CH) bias_m[bus.bias_addr] = longint'(bus.bias_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    clock_cycle(); clock_cycle();
    checks++; if (snap_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %0b want 0", snap_out_valid); end
    checks++; if (snap_data !== 16'sd0) begin errors++; $display("[TB] FAIL reset out_data: got %0d want 0", snap_data); end
    checks++; if (snap_ch !== 4'd0) begin errors++; $display("[TB] FAIL reset out_ch: got %0d want 0", snap_ch); end
    checks++; if (snap_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %0b want 1", snap_in_ready); end
    rst = 0;
    clock_cycle();
  endtask

  task automatic test_basic();
    logic signed [31:0] tbl_bias [4] = '{32'sd100, -32'sd50, 32'sd0, 32'sh7FFF_0000};
    logic signed [15:0] tbl_exp  [4] = '{16'sd1, 16'sd0, 16'sd1, 16'sd32767};
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      bus.bias_we = 1; bus.bias_addr = 4'(i); bus.bias_wdata = tbl_bias[i];
      clock_cycle();
    end
    bus.bias_we = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c < 4); bus.in_data = 32'sd256;
      clock_cycle();
      if (got_hand) begin
        checks++;
        if (n >= 4 || got_data !== tbl_exp[n] || got_ch !== 4'(n)) begin
          errors++; $display("[TB] FAIL basic beat %0d: got data=%0d ch=%0d want data=%0d ch=%0d", n, got_data, got_ch, tbl_exp[n % 4], n);
        end
        n++;
      end
    end
    checks++; if (n != 4) begin errors++; $display("[TB] FAIL basic count: got %0d want 4", n); end
    exp_q.delete();
  endtask

  task automatic test_stream();
    int first_hand = -1, hands = 0, wraps = 0;
    logic [3:0] prev_ch = 4'd0;
    for (int i = 0; i < N_CH; i++) begin
      bus.bias_we = 1; bus.bias_addr = 4'(i); bus.bias_wdata = 32'($urandom_range(0, 1 << 20)) - 32'sd524288;
      clock_cycle();
    end
    bus.bias_we = 0; bus.ch_clr = 1; clock_cycle(); bus.ch_clr = 0;
    for (int c = 0; c < 44; c++) begin
      bus.in_valid = (c < 40);
      bus.in_data = (c % 3 == 0) ? 32'($urandom) : 32'($urandom_range(0, 1 << 22)) - 32'sd2097152;
      clock_cycle();
      if (c < 40) begin
        checks++; if (snap_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stream in_ready c=%0d: got %0b want 1", c, snap_in_ready); end
      end
      if (got_hand) begin
        checks++;
        if (!exp_ok || got_data !== exp_data || got_ch !== exp_ch) begin
          errors++; $display("[TB] FAIL stream beat: got data=%0d ch=%0d want data=%0d ch=%0d", got_data, got_ch, exp_data, exp_ch);
        end
        if (first_hand < 0) first_hand = c;
        if (hands > 0 && prev_ch == 4'd15 && got_ch == 4'd0) wraps++;
        prev_ch = got_ch; hands++;
      end
    end
    checks++; if (first_hand != 2) begin errors++; $display("[TB] FAIL stream latency: got cycle %0d want 2", first_hand); end
    checks++; if (hands != 40) begin errors++; $display("[TB] FAIL stream count: got %0d want 40", hands); end
    checks++; if (wraps != 2) begin errors++; $display("[TB] FAIL stream wraps: got %0d want 2", wraps); end
  endtask

  task automatic test_stall();
    int accs = 0, hands = 0;
    for (int c = 0; c < 36; c++) begin
      bus.in_valid = (c < 8) ? 1'b1 : ((c < 26) ? ($urandom % 4 != 0) : 1'b0);
      bus.in_data = 32'($urandom);
      bus.out_ready = !(c >= 8 && c <= 12);
      clock_cycle();
      accs += int'(got_acc);
      if (c >= 8 && c <= 12) begin
        checks++; if (snap_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall in_ready c=%0d: got %0b want 0", c, snap_in_ready); end
        checks++;
        if (snap_out_valid !== 1'b1 || exp_q.size() == 0 || snap_data !== exp_q[0].data || snap_ch !== exp_q[0].ch) begin
          errors++; $display("[TB] FAIL stall hold c=%0d: got valid=%0b data=%0d ch=%0d", c, snap_out_valid, snap_data, snap_ch);
        end
      end
      if (got_hand) begin
        hands++; checks++;
        if (!exp_ok || got_data !== exp_data || got_ch !== exp_ch) begin
          errors++; $display("[TB] FAIL stall beat: got data=%0d ch=%0d want data=%0d ch=%0d", got_data, got_ch, exp_data, exp_ch);
        end
      end
    end
    bus.out_ready = 1;
    checks++; if (hands != accs || exp_q.size() != 0) begin errors++; $display("[TB] FAIL stall count: got %0d results want %0d", hands, accs); end
  endtask

  task automatic test_bias_same_cycle();
    int seen = 0;
    logic signed [15:0] ch3_exp [2] = '{16'sd2, 16'sd5};
    bus.ch_clr = 1; bus.bias_we = 1; bus.bias_addr = 4'd3; bus.bias_wdata = 32'sd512;
    clock_cycle();
    bus.ch_clr = 0;
    for (int c = 0; c < 24; c++) begin
      bus.in_valid = (c < 20); bus.in_data = '0;
      bus.bias_we = (c == 3); bus.bias_wdata = 32'sd1280;
      clock_cycle();
      if (got_hand) begin
        checks++;
        if (!exp_ok || got_data !== exp_data || got_ch !== exp_ch) begin
          errors++; $display("[TB] FAIL bias beat: got data=%0d ch=%0d want data=%0d ch=%0d", got_data, got_ch, exp_data, exp_ch);
        end
        if (got_ch == 4'd3) begin
          checks++;
          if (seen >= 2 || got_data !== ch3_exp[seen % 2]) begin
            errors++; $display("[TB] FAIL bias ch3 use %0d: got %0d want %0d", seen, got_data, ch3_exp[seen % 2]);
          end
          seen++;
        end
      end
    end
    bus.bias_we = 0;
    checks++; if (seen != 2) begin errors++; $display("[TB] FAIL bias ch3 count: got %0d want 2", seen); end
  endtask

  task automatic test_ch_clr();
    int n = 0;
    bus.ch_clr = 1; clock_cycle();
    for (int c = 0; c < 13; c++) begin
      bus.in_valid = (c < 9); bus.in_data = 32'($urandom);
      bus.ch_clr = (c == 7);
      clock_cycle();
      if (got_hand) begin
        checks++;
        if (!exp_ok || got_data !== exp_data || got_ch !== exp_ch) begin
          errors++; $display("[TB] FAIL clr beat: got data=%0d ch=%0d want data=%0d ch=%0d", got_data, got_ch, exp_data, exp_ch);
        end
        if (n == 7 || n == 8) begin
          checks++;
          if (got_ch !== ((n == 7) ? 4'd7 : 4'd0)) begin
            errors++; $display("[TB] FAIL clr tag beat %0d: got %0d want %0d", n, got_ch, (n == 7) ? 7 : 0);
          end
        end
        n++;
      end
    end
    bus.ch_clr = 0;
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 100; c++) begin
      bus.in_valid = (c < 90) && ($urandom % 4 != 0);
      bus.in_data = 32'($urandom);
      bus.out_ready = (c >= 90) || ($urandom % 3 != 0);
      bus.bias_we = ($urandom % 6 == 0); bus.bias_addr = 4'($urandom); bus.bias_wdata = 32'($urandom);
      bus.ch_clr = ($urandom % 25 == 0);
      clock_cycle();
      if (got_hand) begin
        checks++;
        if (!exp_ok || got_data !== exp_data || got_ch !== exp_ch) begin
          errors++; $display("[TB] FAIL random beat c=%0d: got data=%0d ch=%0d want data=%0d ch=%0d", c, got_data, got_ch, exp_data, exp_ch);
        end
      end
    end
    drive_idle();
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL random drain: %0d results outstanding want 0", exp_q.size()); end
  endtask

  task automatic test_relu_off();
    logic signed [31:0] d [14];
    logic signed [15:0] want;
    d[0] = -32'sd1024; d[1] = 32'sh8000_0000;
    for (int i = 2; i < 14; i++) d[i] = 32'($urandom);
    for (int c = 0; c < 16; c++) begin
      bus2.in_valid = (c < 14); bus2.in_data = d[c % 14];
      @(negedge clk);
      checks++;
      if (c < 2) begin
        if (bus2.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL relu_off early valid c=%0d: got %0b want 0", c, bus2.out_valid); end
      end else begin
        want = act_model(longint'(d[c-2]), 0, 1'b0);
        if (bus2.out_valid !== 1'b1 || bus2.out_data !== want || bus2.out_ch !== 4'((c - 2) % N2)) begin
          errors++; $display("[TB] FAIL relu_off beat %0d: got valid=%0b data=%0d ch=%0d want data=%0d ch=%0d",
                             c - 2, bus2.out_valid, bus2.out_data, bus2.out_ch, want, (c - 2) % N2);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (bus2.out_data !== ((c == 2) ? -16'sd4 : -16'sd32768)) begin
          errors++; $display("[TB] FAIL relu_off fixed c=%0d: got %0d want %0d", c, bus2.out_data, (c == 2) ? -4 : -32768);
        end
      end
      @(posedge clk); #1;
    end
    bus2.in_valid = 0;
  endtask

  task automatic test_reset_mid();
    int hands = 0;
    for (int c = 0; c < 3; c++) begin
      bus.in_valid = 1; bus.in_data = 32'($urandom);
      clock_cycle();
    end
    rst = 1; clock_cycle();
    rst = 0; bus.in_valid = 0;
    for (int c = 0; c < 2; c++) begin
      clock_cycle();
      checks++; if (snap_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid out_valid c=%0d: got %0b want 0", c, snap_out_valid); end
    end
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = (c == 0); bus.in_data = 32'sd512;
      clock_cycle();
      if (got_hand) begin
        hands++; checks++;
        if (got_data !== 16'sd2 || got_ch !== 4'd0) begin
          errors++; $display("[TB] FAIL reset_mid cleared bias: got data=%0d ch=%0d want data=2 ch=0", got_data, got_ch);
        end
      end
    end
    checks++; if (hands != 1) begin errors++; $display("[TB] FAIL reset_mid count: got %0d want 1", hands); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] bias_act_stream bench start");
    test_reset();
    test_basic();
    test_stream();
    test_stall();
    test_bias_same_cycle();
    test_ch_clr();
    test_back_to_back();
    test_relu_off();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
